// File: rtl/input_conditioner.sv
// input_conditioner: synchronises, debounces and edge-detects the keypad front panel.
//
// Ports:
//   CLK          system clock, rising edge
//   RESET_N      asynchronous active-low reset (release is synchronised internally)
//   SW[9:0]      raw slide switches (asynchronous)
//   BTN[2:0]     raw buttons (asynchronous): [0] ADMIN, [1] OK, [2] BACKSPACE
//   SW_STABLE    debounced switch levels
//   CODE_VALID   one-cycle pulse when a debounced switch rises
//   CODE_DIGIT   index of the rising switch (lowest wins), held until the next CODE_VALID
//   BTN_PRESS    one-cycle pulse when a debounced button rises (or autorepeats)
//   BTN_WHICH    0=ADMIN 1=OK 2=BACKSPACE, held until the next BTN_PRESS
//   MS_TICK      one-cycle pulse every CLK_DIV cycles
//
// Build option: define INPUT_CONDITIONER_BTN_REPEAT_EN to enable BACKSPACE autorepeat.
module input_conditioner #(
  parameter int unsigned CLK_DIV     = 100000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned REPEAT_MS   = 250
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [9:0] SW,
  input  logic [2:0] BTN,
  output logic [9:0] SW_STABLE,
  output logic       CODE_VALID,
  output logic [3:0] CODE_DIGIT,
  output logic       BTN_PRESS,
  output logic [1:0] BTN_WHICH,
  output logic       MS_TICK
);

  localparam int unsigned NumIn = 13;
  localparam int unsigned TickW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BsIdx = 12;

  // Reset: assert asynchronously, deassert two edges after RESET_N rises.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  // Inputs are packed as {BTN, SW}: bits 9..0 switches, 12..10 buttons.
  logic [NumIn-1:0]      meta_q, sync_q;
  logic [NumIn-1:0]      deb_q, deb_d, deb_prev_q;
  logic [NumIn-1:0][4:0] hold_q, hold_d;
  logic [TickW-1:0]      tick_cnt_q, tick_cnt_d;
  logic                  ms_tick;
  logic [9:0]            sw_rise;
  logic [2:0]            btn_rise;
  logic                  cv_q, cv_d, bp_q, bp_d;
  logic [3:0]            digit_q, digit_d;
  logic [1:0]            which_q, which_d;
  logic                  rep_req;

  assign ms_tick    = (tick_cnt_q == TickW'(CLK_DIV - 1));
  assign tick_cnt_d = ms_tick ? '0 : tick_cnt_q + TickW'(1);

  // Hold counter restarts whenever the input agrees with its accepted level.
  always_comb begin
    deb_d  = deb_q;
    hold_d = hold_q;
    for (int i = 0; i < NumIn; i++) begin
      if (sync_q[i] == deb_q[i]) begin
        hold_d[i] = '0;
      end else if (ms_tick) begin
        if (hold_q[i] + 5'd1 == 5'(DEBOUNCE_MS)) begin
          deb_d[i]  = sync_q[i];
          hold_d[i] = '0;
        end else begin
          hold_d[i] = hold_q[i] + 5'd1;
        end
      end
    end
  end

  assign sw_rise  = deb_q[9:0] & ~deb_prev_q[9:0];
  assign btn_rise = deb_q[12:10] & ~deb_prev_q[12:10];

  // Lowest switch index wins; other simultaneous rises are dropped.
  always_comb begin
    cv_d    = |sw_rise;
    digit_d = digit_q;
    for (int i = 9; i >= 0; i--) begin
      if (sw_rise[i]) digit_d = 4'(i);
    end
  end

  // Fresh presses beat an autorepeat request landing in the same cycle.
  always_comb begin
    bp_d    = 1'b0;
    which_d = which_q;
    if (btn_rise[0]) begin
      bp_d    = 1'b1;
      which_d = 2'd0;
    end else if (btn_rise[1]) begin
      bp_d    = 1'b1;
      which_d = 2'd1;
    end else if (btn_rise[2] || rep_req) begin
      bp_d    = 1'b1;
      which_d = 2'd2;
    end
  end

`ifdef INPUT_CONDITIONER_BTN_REPEAT_EN
  localparam int unsigned RepW = $clog2(2 * REPEAT_MS + 1);

  logic [RepW-1:0] rep_cnt_q, rep_cnt_d, rep_thresh;
  logic            rep_first_q, rep_first_d;

  // First repeat waits twice as long as the following ones.
  assign rep_thresh = rep_first_q ? RepW'(2 * REPEAT_MS) : RepW'(REPEAT_MS);
  assign rep_req    = deb_q[BsIdx] && (rep_cnt_q == rep_thresh);

  // The request is consumed even when ADMIN/OK wins the cycle.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    if (!deb_q[BsIdx]) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b1;
    end else if (rep_req) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b0;
    end else if (ms_tick) begin
      rep_cnt_d = rep_cnt_q + RepW'(1);
    end
  end

  always_ff @(posedge CLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  assign rep_req = 1'b0;
`endif

  always_ff @(posedge CLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      meta_q     <= '0;
      sync_q     <= '0;
      tick_cnt_q <= '0;
      hold_q     <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      cv_q       <= 1'b0;
      digit_q    <= '0;
      bp_q       <= 1'b0;
      which_q    <= '0;
    end else begin
      meta_q     <= {BTN, SW};
      sync_q     <= meta_q;
      tick_cnt_q <= tick_cnt_d;
      hold_q     <= hold_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cv_q       <= cv_d;
      digit_q    <= digit_d;
      bp_q       <= bp_d;
      which_q    <= which_d;
    end
  end

  assign SW_STABLE  = deb_q[9:0];
  assign CODE_VALID = cv_q;
  assign CODE_DIGIT = digit_q;
  assign BTN_PRESS  = bp_q;
  assign BTN_WHICH  = which_q;
  assign MS_TICK    = ms_tick;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with CLK_DIV=4, DEBOUNCE_MS=3, REPEAT_MS=2.
// A tick-level model predicts every output each cycle; directed scenarios add
// hand-computed expectations (latencies, digits, tick positions, pulse gaps).
module tb_input_conditioner;

  localparam int CLK_DIV = 4;
  localparam int DEB     = 3;
  localparam int REP     = 2;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [9:0] SW;
  logic [2:0] BTN;
  logic [9:0] SW_STABLE;
  logic       CODE_VALID;
  logic [3:0] CODE_DIGIT;
  logic       BTN_PRESS;
  logic [1:0] BTN_WHICH;
  logic       MS_TICK;

  input_conditioner #(
    .CLK_DIV    (CLK_DIV),
    .DEBOUNCE_MS(DEB),
    .REPEAT_MS  (REP)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .SW        (SW),
    .BTN       (BTN),
    .SW_STABLE (SW_STABLE),
    .CODE_VALID(CODE_VALID),
    .CODE_DIGIT(CODE_DIGIT),
    .BTN_PRESS (BTN_PRESS),
    .BTN_WHICH (BTN_WHICH),
    .MS_TICK   (MS_TICK)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic chk_range(input string name, input longint got, input longint lo,
                           input longint hi);
    n_chk++;
    if (got >= lo && got <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
  endtask

  // ---------------- behavioural model ----------------
  // m_rel counts edges since RESET_N rose; the first two only release the reset.
  int          m_rel;
  logic [12:0] m_s1, m_s2, m_deb, m_swr;
  logic [2:0]  m_btr;
  int          m_ht[13];
  logic        m_cv, m_bp, m_tick;
  logic [3:0]  m_digit;
  logic [1:0]  m_which;
  int          m_rt;
  bit          m_first, m_due;

  task automatic model_step();
    int c;
    bit tk;
    if (!RESET_N) begin
      m_rel = 0; m_s1 = '0; m_s2 = '0; m_deb = '0; m_swr = '0; m_btr = '0;
      for (int i = 0; i < 13; i++) m_ht[i] = 0;
      m_cv = 0; m_bp = 0; m_tick = 0; m_digit = '0; m_which = '0;
      m_rt = 0; m_first = 1; m_due = 0;
      return;
    end
    if (m_rel < 1000000) m_rel++;
    if (m_rel >= 3) begin
      c  = m_rel - 2;  // cycle index that ends at this edge
      tk = (c % CLK_DIV == 0);
      m_cv = 0;
      for (int i = 9; i >= 0; i--) if (m_swr[i]) begin m_cv = 1; m_digit = 4'(i); end
      m_bp = 0;
      if (m_btr[0])      begin m_bp = 1; m_which = 2'd0; end
      else if (m_btr[1]) begin m_bp = 1; m_which = 2'd1; end
      else if (m_btr[2]) begin m_bp = 1; m_which = 2'd2; end
`ifdef INPUT_CONDITIONER_BTN_REPEAT_EN
      if (!m_bp && m_due && m_deb[12]) begin m_bp = 1; m_which = 2'd2; end
      if (!m_deb[12]) begin
        m_rt = 0; m_first = 1; m_due = 0;
      end else if (m_due) begin
        m_rt = 0; m_first = 0; m_due = 0;
      end else if (tk) begin
        m_rt++;
        if (m_rt == (m_first ? 2 * REP : REP)) m_due = 1;
      end
`endif
      m_swr = '0;
      m_btr = '0;
      for (int i = 0; i < 13; i++) begin
        if (m_s2[i] != m_deb[i]) begin
          if (tk) begin
            m_ht[i]++;
            if (m_ht[i] == DEB) begin
              m_deb[i] = m_s2[i];
              m_ht[i]  = 0;
              if (m_s2[i]) begin
                if (i < 10) m_swr[i] = 1'b1;
                else        m_btr[i-10] = 1'b1;
              end
            end
          end
        end else begin
          m_ht[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = {BTN, SW};
    end
    m_tick = (m_rel >= 2) && ((m_rel - 1) % CLK_DIV == 0);
  endtask

  initial begin
    forever begin
      @(posedge CLK or negedge RESET_N);
      model_step();
    end
  end

  // ---------------- cycle counter, compare and pulse monitor ----------------
  int posedge_cnt = 0;
  always @(posedge CLK) posedge_cnt <= posedge_cnt + 1;

  int         cv_cnt = 0, cv_time = 0, bp_cnt = 0;
  logic [3:0] cv_digit = '0;
  logic [1:0] bp_which_first = '0;
  int         bp_times[8];

  logic [18:0] got_vec, exp_vec;
  always @(negedge CLK) begin
    got_vec = {SW_STABLE, CODE_VALID, CODE_DIGIT, BTN_PRESS, BTN_WHICH, MS_TICK};
    exp_vec = {m_deb[9:0], m_cv, m_digit, m_bp, m_which, m_tick};
    n_chk++;
    if (got_vec == exp_vec) n_pass++;
    else $display("FAIL cycle_compare @%0d: got %h, expected %h", posedge_cnt, got_vec, exp_vec);
    if (CODE_VALID) begin
      cv_cnt++;
      cv_time  = posedge_cnt;
      cv_digit = CODE_DIGIT;
    end
    if (BTN_PRESS) begin
      if (bp_cnt == 0) bp_which_first = BTN_WHICH;
      if (bp_cnt < 8) bp_times[bp_cnt] = posedge_cnt;
      bp_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // ---------------- directed scenarios ----------------
  logic [31:0] tick_mask;
  int          p;

  initial begin
    SW = '0; BTN = '0; RESET_N = 1'b1;
    #1 RESET_N = 1'b0;
    wait_cyc(3);
    #2 RESET_N = 1'b1;

    // Idle after release: ticks at cycles 4,8,12,16,20 only.
    tick_mask = '0;
    for (int k = 1; k <= 21; k++) begin
      @(negedge CLK);
      if (MS_TICK) tick_mask = tick_mask | (32'd1 << (k - 1));
    end
    chk("tick_positions", tick_mask, 32'h0011_1110);
    chk("idle_no_code_valid", cv_cnt, 0);
    chk("idle_no_btn_press", bp_cnt, 0);
    chk("idle_sw_stable", SW_STABLE, 0);

    // SW[5] rises and holds.
    SW = 10'h020;
    p  = posedge_cnt;
    wait_cyc(30);
    chk("sw5_pulse_count", cv_cnt, 1);
    chk_range("sw5_latency", cv_time - p, 12, 16);
    chk("sw5_digit", cv_digit, 5);
    chk("sw5_sw_stable", SW_STABLE, 10'h020);
    SW = '0;
    wait_cyc(25);
    chk("sw5_fall_no_pulse", cv_cnt, 1);
    chk("sw5_fall_sw_stable", SW_STABLE, 0);

    // OK glitch of 6 cycles is rejected.
    BTN = 3'b010;
    wait_cyc(6);
    BTN = 3'b000;
    wait_cyc(30);
    chk("ok_glitch_no_press", bp_cnt, 0);
    chk("ok_glitch_which", BTN_WHICH, 0);

    // Simultaneous SW[7]+SW[2] and ADMIN+BACKSPACE.
    cv_cnt = 0;
    SW  = 10'h084;
    BTN = 3'b101;
    wait_cyc(20);
    chk("multi_code_valid_count", cv_cnt, 1);
    chk("multi_btn_press_count", bp_cnt, 1);
    chk("multi_same_cycle", bp_times[0], cv_time);
    chk("multi_digit_lowest", cv_digit, 2);
    chk("multi_which_admin", bp_which_first, 0);
    SW  = '0;
    BTN = '0;
    wait_cyc(40);
    chk("multi_no_late_code_valid", cv_cnt, 1);

    // Reset 8 cycles after SW[4] rises; the switch is re-accepted after release.
    cv_cnt = 0;
    SW = 10'h010;
    wait_cyc(8);
    #2 RESET_N = 1'b0;
    #1;
    chk("reset_outputs_zero",
        {SW_STABLE, CODE_VALID, CODE_DIGIT, BTN_PRESS, BTN_WHICH, MS_TICK}, 0);
    chk("reset_no_early_pulse", cv_cnt, 0);
    wait_cyc(3);
    #2 RESET_N = 1'b1;
    p = posedge_cnt;
    wait_cyc(25);
    chk("post_reset_pulse_count", cv_cnt, 1);
    chk_range("post_reset_latency", cv_time - p, 14, 17);
    chk("post_reset_digit", cv_digit, 4);
    SW = '0;
    wait_cyc(20);

    // BACKSPACE held 40 cycles.
    bp_cnt = 0;
    BTN = 3'b100;
    wait_cyc(40);
    BTN = 3'b000;
    wait_cyc(40);
    chk("bs_which", BTN_WHICH, 2);
`ifdef INPUT_CONDITIONER_BTN_REPEAT_EN
    chk_range("bs_press_count", bp_cnt, 3, 8);
    chk("bs_first_repeat_gap", bp_times[1] - bp_times[0], 16);
    chk("bs_next_repeat_gap", bp_times[2] - bp_times[1], 8);
`else
    chk("bs_press_count", bp_cnt, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
